// File: rtl/bj_pkg.sv
// ============================================================================
// Module      : bj_pkg
// Description : Shared definitions for the branch/jump resolve controller.
//               One-hot BJ op bit indices, controller state encoding and the
//               packed control portion of a latched op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bj_pkg;

  // Bit positions inside the one-hot {Jump,Bne,Beq,Bge,Blt} op vector
  localparam int unsigned BJ_JUMP = 4;
  localparam int unsigned BJ_BNE  = 3;
  localparam int unsigned BJ_BEQ  = 2;
  localparam int unsigned BJ_BGE  = 1;
  localparam int unsigned BJ_BLT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESOLVE  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } bj_state_e;

  // Control fields of a latched op; the XLEN-wide operands are kept in
  // separate registers so the package stays width-independent.
  typedef struct packed {
    logic [4:0] bj_op;
    logic       is_jalr;
    logic       cmp_unsigned;
    logic       pred_taken;
  } bj_op_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/bj_cond_eval.sv
// ============================================================================
// Module      : bj_cond_eval
// Description : Purely combinational resolution of a latched branch/jump op:
//               direction, target and mispredict against the prediction.
// Ports       : ctrl_i        latched op control fields
//               pc_i, rs1_i, rs2_i, imm_i  latched operands
//               pred_target_i latched predicted target
//               taken_o       resolved direction
//               target_o      resolved target (valid when taken)
//               mispred_o     resolution disagrees with the prediction
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bj_cond_eval
  import bj_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  bj_op_ctrl_t       ctrl_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   pred_target_i,
  output logic              taken_o,
  output logic [XLEN-1:0]   target_o,
  output logic              mispred_o
);

  logic w_lt;

  always_comb begin
    w_lt = ctrl_i.cmp_unsigned ? (rs1_i < rs2_i)
                               : ($signed(rs1_i) < $signed(rs2_i));

    // All-zero (illegal) op falls through to not-taken
    taken_o = 1'b0;
    if (ctrl_i.bj_op[BJ_JUMP])     taken_o = 1'b1;
    else if (ctrl_i.bj_op[BJ_BNE]) taken_o = (rs1_i != rs2_i);
    else if (ctrl_i.bj_op[BJ_BEQ]) taken_o = (rs1_i == rs2_i);
    else if (ctrl_i.bj_op[BJ_BGE]) taken_o = ~w_lt;
    else if (ctrl_i.bj_op[BJ_BLT]) taken_o = w_lt;

    // JALR clears bit 0 of the register-relative target
    if (ctrl_i.bj_op[BJ_JUMP] && ctrl_i.is_jalr)
      target_o = (rs1_i + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
    else
      target_o = pc_i + imm_i;

    mispred_o = (taken_o != ctrl_i.pred_taken) ||
                (taken_o && (target_o != pred_target_i));
  end

endmodule

`default_nettype wire

// File: rtl/bj_resolve_ctrl.sv
// ============================================================================
// Module      : bj_resolve_ctrl
// Description : Branch/jump execute-slot sequencer. Accepts one op per
//               handshake, resolves it one cycle later, and on a mispredict
//               holds a redirect to fetch then drives a FLUSH_CYCLES flush.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready, bj_op, is_jalr, cmp_unsigned,
//               pc, rs1, rs2, imm, pred_taken, pred_target   op input
//               res_valid, res_taken, link_we, link_data     resolve result
//               redir_valid/redir_ready, redir_pc            redirect to fetch
//               flush                                        squash younger
//               mispred_cnt   saturating mispredict count, present only
//                             when BJ_MISPRED_CNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bj_resolve_ctrl
  import bj_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        bj_op,
  input  logic              is_jalr,
  input  logic              cmp_unsigned,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [XLEN-1:0]   imm,
  input  logic              pred_taken,
  input  logic [XLEN-1:0]   pred_target,
  output logic              res_valid,
  output logic              res_taken,
  output logic              link_we,
  output logic [XLEN-1:0]   link_data,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [XLEN-1:0]   redir_pc,
  output logic              flush
`ifdef BJ_MISPRED_CNT_EN
  ,
  output logic [31:0]       mispred_cnt
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  bj_state_e       state_q, state_d;
  bj_op_ctrl_t     ctrl_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, pred_target_q;
  logic [XLEN-1:0] redir_pc_q;
  logic [3:0]      flush_cnt_q;

  logic            w_taken, w_mispred;
  logic [XLEN-1:0] w_target, w_pc4, w_next_pc;

  bj_cond_eval #(.XLEN(XLEN)) u_cond (
    .ctrl_i        (ctrl_q),
    .pc_i          (pc_q),
    .rs1_i         (rs1_q),
    .rs2_i         (rs2_q),
    .imm_i         (imm_q),
    .pred_target_i (pred_target_q),
    .taken_o       (w_taken),
    .target_o      (w_target),
    .mispred_o     (w_mispred)
  );

  assign w_pc4     = pc_q + XLEN'(4);
  assign w_next_pc = w_taken ? w_target : w_pc4;

  // Next-state and outputs; every output depends only on registered state
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    res_taken   = 1'b0;
    link_we     = 1'b0;
    link_data   = '0;
    redir_valid = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        res_valid = 1'b1;
        res_taken = w_taken;
        link_we   = ctrl_q.bj_op[BJ_JUMP];
        link_data = w_pc4;
        state_d   = w_mispred ? ST_REDIRECT : ST_IDLE;
      end
      ST_REDIRECT: begin
        redir_valid = 1'b1;
        if (redir_ready) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q == 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign redir_pc = redir_pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pred_target_q <= '0;
      redir_pc_q    <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid) begin
        ctrl_q.bj_op        <= bj_op;
        ctrl_q.is_jalr      <= is_jalr;
        ctrl_q.cmp_unsigned <= cmp_unsigned;
        ctrl_q.pred_taken   <= pred_taken;
        pc_q                <= pc;
        rs1_q               <= rs1;
        rs2_q               <= rs2;
        imm_q               <= imm;
        pred_target_q       <= pred_target;
      end
      if (state_q == ST_RESOLVE && w_mispred)
        redir_pc_q <= w_next_pc;
      if (state_q == ST_REDIRECT && redir_ready)
        flush_cnt_q <= FLUSH_LOAD;
      else if (state_q == ST_FLUSH && flush_cnt_q != 4'd0)
        flush_cnt_q <= flush_cnt_q - 4'd1;
    end
  end

`ifdef BJ_MISPRED_CNT_EN
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      mispred_cnt_q <= '0;
    else if (state_q == ST_RESOLVE && w_mispred && mispred_cnt_q != 32'hFFFF_FFFF)
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
  end

  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bj_resolve_ctrl.sv
// ============================================================================
// Module      : tb_bj_resolve_ctrl
// Description : Directed self-checking bench for bj_resolve_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bj_resolve_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      bj_op;
  logic            is_jalr;
  logic            cmp_unsigned;
  logic [XLEN-1:0] pc, rs1, rs2, imm, pred_target;
  logic            pred_taken;
  logic            res_valid, res_taken, link_we;
  logic [XLEN-1:0] link_data;
  logic            redir_valid, redir_ready;
  logic [XLEN-1:0] redir_pc;
  logic            flush;
`ifdef BJ_MISPRED_CNT_EN
  logic [31:0]     mispred_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bj_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bj_op        (bj_op),
    .is_jalr      (is_jalr),
    .cmp_unsigned (cmp_unsigned),
    .pc           (pc),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .link_we      (link_we),
    .link_data    (link_data),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_pc     (redir_pc),
    .flush        (flush)
`ifdef BJ_MISPRED_CNT_EN
    ,
    .mispred_cnt  (mispred_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] op, input logic jalr, input logic uns,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic pt, input logic [31:0] ptgt);
    bj_op = op; is_jalr = jalr; cmp_unsigned = uns;
    pc = p; rs1 = a; rs2 = b; imm = im; pred_taken = pt; pred_target = ptgt;
  endtask

  // Present one op in IDLE, then check the RESOLVE cycle.
  task automatic issue(input string tag, input logic exp_taken, input logic exp_link,
                       input logic [31:0] exp_link_data);
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".res_taken"}, 32'(res_taken), 32'(exp_taken));
    chk({tag, ".link_we"},   32'(link_we),   32'(exp_link));
    if (exp_link) chk({tag, ".link_data"}, link_data, exp_link_data);
    chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    int flush_len;
    int accepts;
    rst_n = 1'b0; in_valid = 1'b0; redir_ready = 1'b0;
    set_op(5'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
    #1;
    step(); step();
    chk("rst.in_ready",    32'(in_ready),    32'd1);
    chk("rst.res_valid",   32'(res_valid),   32'd0);
    chk("rst.res_taken",   32'(res_taken),   32'd0);
    chk("rst.link_we",     32'(link_we),     32'd0);
    chk("rst.link_data",   link_data,        32'd0);
    chk("rst.redir_valid", 32'(redir_valid), 32'd0);
    chk("rst.redir_pc",    redir_pc,         32'd0);
    chk("rst.flush",       32'(flush),       32'd0);
`ifdef BJ_MISPRED_CNT_EN
    chk("rst.mispred_cnt", mispred_cnt,      32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Beq taken, correctly predicted; stray redir_ready must be ignored
    redir_ready = 1'b1;
    set_op(5'b00100, 1'b0, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120);
    issue("beq", 1'b1, 1'b0, 32'h0);
    redir_ready = 1'b0;
    step();
    chk("beq.no_redir", 32'(redir_valid), 32'd0);
    chk("beq.idle",     32'(in_ready),    32'd1);
    chk("beq.no_flush", 32'(flush),       32'd0);

    // Blt signed: -1 < 1 -> taken
    set_op(5'b00001, 1'b0, 1'b0, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h310);
    issue("blt_s", 1'b1, 1'b0, 32'h0);
    step();
    chk("blt_s.no_redir", 32'(redir_valid), 32'd0);
    // Blt unsigned: 0xFFFFFFFF < 1 false -> not taken
    set_op(5'b00001, 1'b0, 1'b1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    issue("blt_u", 1'b0, 1'b0, 32'h0);
    step();
    chk("blt_u.no_redir", 32'(redir_valid), 32'd0);
    // Bge unsigned: 0xFFFFFFFF >= 1 -> taken
    set_op(5'b00010, 1'b0, 1'b1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h310);
    issue("bge_u", 1'b1, 1'b0, 32'h0);
    step();
    chk("bge_u.no_redir", 32'(redir_valid), 32'd0);

    // Bne mispredicted (predicted not-taken), redirect stalled 3 cycles
    set_op(5'b01000, 1'b0, 1'b0, 32'h200, 32'd1, 32'd2, 32'hFFFF_FFF8, 1'b0, 32'h0);
    issue("bne", 1'b1, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bne.redir_valid_hold", 32'(redir_valid), 32'd1);
      chk("bne.redir_pc_hold",    redir_pc,         32'h1F8);
      chk("bne.no_flush_yet",     32'(flush),       32'd0);
      step();
    end
    redir_ready = 1'b1;
    chk("bne.redir_valid_hs", 32'(redir_valid), 32'd1);
    chk("bne.redir_pc_hs",    redir_pc,         32'h1F8);
    step();
    redir_ready = 1'b0;
    chk("bne.flush_first", 32'(flush), 32'd1);
    flush_len = 0;
    for (int i = 0; i < 20 && flush; i++) begin
      flush_len++;
      step();
    end
    chk("bne.flush_len",   32'(flush_len),   32'(FLUSH_CYCLES));
    chk("bne.idle_after",  32'(in_ready),    32'd1);
    chk("bne.redir_clear", 32'(redir_valid), 32'd0);
`ifdef BJ_MISPRED_CNT_EN
    chk("bne.mispred_cnt", mispred_cnt, 32'd1);
`endif

    // JALR: (0x1003+4)&~1 = 0x1006, predicted 0x1004 -> mispredict
    set_op(5'b10000, 1'b1, 1'b0, 32'h400, 32'h1003, 32'h0, 32'd4, 1'b1, 32'h1004);
    issue("jalr", 1'b1, 1'b1, 32'h404);
    step();
    chk("jalr.redir_valid", 32'(redir_valid), 32'd1);
    chk("jalr.redir_pc",    redir_pc,         32'h1006);
    // Reset while in REDIRECT drops the pending redirect
    rst_n = 1'b0;
    step();
    chk("rst_mid.redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_mid.in_ready",    32'(in_ready),    32'd1);
    chk("rst_mid.redir_pc",    redir_pc,         32'd0);
    chk("rst_mid.flush",       32'(flush),       32'd0);
`ifdef BJ_MISPRED_CNT_EN
    chk("rst_mid.mispred_cnt", mispred_cnt,      32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Illegal all-zero op predicted taken: not-taken, no link, redirect to pc+4
    set_op(5'b00000, 1'b0, 1'b0, 32'h500, 32'd7, 32'd7, 32'h40, 1'b1, 32'h540);
    issue("illegal", 1'b0, 1'b0, 32'h0);
    step();
    chk("illegal.redir_valid", 32'(redir_valid), 32'd1);
    chk("illegal.redir_pc",    redir_pc,         32'h504);
    redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;
    for (int i = 0; i < 20 && flush; i++) step();
    chk("illegal.idle_after", 32'(in_ready), 32'd1);

    // Back-to-back: in_valid held 4 cycles, no mispredict -> 2 accepts
    set_op(5'b00100, 1'b0, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120);
    in_valid = 1'b1;
    accepts  = 0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b.in_ready_alt", 32'(in_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (in_ready) accepts++;
      step();
    end
    in_valid = 1'b0;
    chk("b2b.accepts", 32'(accepts), 32'd2);
    chk("b2b.idle_end", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
